// File: rtl/cache_defs.sv
// cache_defs: size and FSM state encodings plus sub-line lane helpers shared by cache_set_assoc.
package cache_defs;

    typedef enum logic [1:0] {SZ_8, SZ_16, SZ_32, SZ_64} size_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOOKUP, ST_WB, ST_FILL_REQ, ST_FILL_WAIT, ST_RESP
    } state_e;

    // Right-aligned bit mask covering the 2^sz bytes of an access.
    function automatic logic [63:0] lane_mask(input logic [1:0] sz);
        return (sz == SZ_64) ? '1 : (64'd1 << (8 << sz)) - 64'd1;
    endfunction

    // Offset bits that must be cleared to align an access of size sz.
    function automatic logic [2:0] align_m1(input logic [1:0] sz);
        return 3'((4'd1 << sz) - 4'd1);
    endfunction

endpackage

// File: rtl/cache_lru_ages.sv
// cache_lru_ages: true-LRU age counters; age 0 is most recent, age WAYS-1 is the victim.
module cache_lru_ages #(
    parameter int WAYS = 4,
    localparam int WW = $clog2(WAYS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          touch,
    input  logic [WW-1:0] touch_way,
    output logic [WW-1:0] victim
);

    logic [WW-1:0] ages [WAYS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            for (int i = 0; i < WAYS; i++) ages[i] <= WW'(i);
        else if (touch)
            for (int i = 0; i < WAYS; i++)
                ages[i] <= (WW'(i) == touch_way) ? '0 :
                           (ages[i] < ages[touch_way]) ? ages[i] + 1'b1 : ages[i];
    end

    always_comb begin
        victim = '0;
        for (int i = 0; i < WAYS; i++)
            if (ages[i] == WW'(WAYS - 1)) victim = WW'(i);
    end

endmodule

// File: rtl/cache_set_assoc.sv
// cache_set_assoc: one N-way set with true-LRU, dirty write-back and single-beat refill.
// Define CACHE_SET_STATS_EN to add saturating hit_count/miss_count outputs.
module cache_set_assoc
    import cache_defs::*;
#(
    parameter int WAYS       = 4,
    parameter int TAG_W      = 20,
    parameter int LINE_BYTES = 64,
    parameter int OFF_W      = $clog2(LINE_BYTES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [TAG_W-1:0]        req_tag,
    input  logic [OFF_W-1:0]        req_offset,
    input  logic [1:0]              req_size,
    input  logic [63:0]             req_wdata,
    output logic                    resp_valid,
    output logic                    resp_hit,
    output logic [63:0]             resp_rdata,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_write,
    output logic [TAG_W-1:0]        mem_req_tag,
    output logic [LINE_BYTES*8-1:0] mem_req_wline,
    input  logic                    mem_fill_valid,
    input  logic [LINE_BYTES*8-1:0] mem_fill_line
`ifdef CACHE_SET_STATS_EN
    ,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
`endif
);

    localparam int WW     = $clog2(WAYS);
    localparam int LINE_W = LINE_BYTES * 8;

    state_e state, state_nx;

    logic [TAG_W-1:0]  tags  [WAYS];
    logic [LINE_W-1:0] lines [WAYS];
    logic [WAYS-1:0]   valid, dirty;

    logic              r_write;
    logic [TAG_W-1:0]  r_tag;
    logic [OFF_W-1:0]  r_off;
    logic [1:0]        r_size;
    logic [63:0]       r_wdata;
    logic [OFF_W+2:0]  sh;

    logic [WW-1:0] victim_q, hit_way, free_way, lru_way, miss_way, touch_way;
    logic          hit, has_free, touch, hit_q;
    logic [63:0]   rdata_q;

    assign sh = {r_off, 3'b000};

    function automatic logic [63:0] ld(input logic [LINE_W-1:0] l);
        return 64'(l >> sh) & lane_mask(r_size);
    endfunction

    function automatic logic [LINE_W-1:0] st(input logic [LINE_W-1:0] l);
        return (l & ~(LINE_W'(lane_mask(r_size)) << sh)) |
               (LINE_W'(r_wdata & lane_mask(r_size)) << sh);
    endfunction

    // Descending scan leaves the lowest-index invalid way in free_way.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        has_free = 1'b0;
        free_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (valid[i] && tags[i] == r_tag) begin
                hit     = 1'b1;
                hit_way = WW'(i);
            end
            if (!valid[i]) begin
                has_free = 1'b1;
                free_way = WW'(i);
            end
        end
    end

    assign miss_way  = has_free ? free_way : lru_way;
    assign touch     = (state == ST_LOOKUP && hit) || (state == ST_FILL_WAIT && mem_fill_valid);
    assign touch_way = (state == ST_LOOKUP) ? hit_way : victim_q;

    cache_lru_ages #(.WAYS(WAYS)) u_lru (
        .clk       (clk),
        .rst_n     (rst_n),
        .touch     (touch),
        .touch_way (touch_way),
        .victim    (lru_way)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_tag   = '0;
        mem_req_wline = '0;
        resp_valid    = 1'b0;
        resp_hit      = 1'b0;
        resp_rdata    = '0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = ST_LOOKUP;
            end
            ST_LOOKUP:
                state_nx = hit ? ST_RESP :
                           (valid[miss_way] && dirty[miss_way]) ? ST_WB : ST_FILL_REQ;
            ST_WB: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_tag   = tags[victim_q];
                mem_req_wline = lines[victim_q];
                if (mem_req_ready) state_nx = ST_FILL_REQ;
            end
            ST_FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_tag   = r_tag;
                if (mem_req_ready) state_nx = ST_FILL_WAIT;
            end
            ST_FILL_WAIT:
                if (mem_fill_valid) state_nx = ST_RESP;
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_hit   = hit_q;
                resp_rdata = rdata_q;
                state_nx   = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else if (state == ST_LOOKUP && hit && r_write) begin
            dirty[hit_way] <= 1'b1;
        end else if (state == ST_FILL_WAIT && mem_fill_valid) begin
            valid[victim_q] <= 1'b1;
            dirty[victim_q] <= r_write;
        end
    end

    // Line storage and request registers are qualified by valid bits and FSM state, so need no reset.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req_valid) begin
            r_write <= req_write;
            r_tag   <= req_tag;
            r_off   <= req_offset & ~OFF_W'(align_m1(req_size));
            r_size  <= req_size;
            r_wdata <= req_wdata;
        end
        if (state == ST_LOOKUP) begin
            victim_q <= miss_way;
            hit_q    <= hit;
            if (hit) begin
                rdata_q <= r_write ? '0 : ld(lines[hit_way]);
                if (r_write) lines[hit_way] <= st(lines[hit_way]);
            end
        end
        if (state == ST_FILL_WAIT && mem_fill_valid) begin
            tags[victim_q]  <= r_tag;
            lines[victim_q] <= r_write ? st(mem_fill_line) : mem_fill_line;
            rdata_q         <= r_write ? '0 : ld(mem_fill_line);
        end
    end

`ifdef CACHE_SET_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == ST_LOOKUP) begin
            if (hit && hit_count != '1)    hit_count  <= hit_count + 32'd1;
            if (!hit && miss_count != '1)  miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule
